multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Moore/Mealy control FSM that sequences the 32-bit multi-cycle datapath: register file, ALU, unified instruction/data memory and the 16-bit immediate extender. Decodes `opcode[5:0]` of the latched instruction, steps each instruction through fetch/decode/execute/memory/write-back and drives every datapath mux and enable. It also selects sign vs zero extension of the immediate for the extender mux.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: max wait cycles for `mem_ready`; 0 disables the timeout.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  leave IDLE and begin fetching.
- `opcode`  in  6  IR[31:26], valid from DECODE onward.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond`  out  1  PC load if `zero`.
- `iord`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `ir_write`  out  1  latch IR.
- `mem_to_reg`  out  1  write-back source: 0 = ALUOut, 1 = MDR.
- `reg_dst`  out  1  destination: 0 = rt, 1 = rd.
- `reg_write`  out  1  register file write enable.
- `alu_src_a`  out  1  0 = PC, 1 = A.
- `alu_src_b`  out  2  00 = B, 01 = 4, 10 = ext(imm), 11 = ext(imm)<<2.
- `alu_op`  out  2  00 add, 01 sub, 10 funct, 11 imm-logic (ALU control uses opcode[1:0]: 00 AND, 01 OR).
- `pc_source`  out  2  00 ALU, 01 ALUOut, 10 jump target.
- `ext_sel`  out  1  1 = sign-extend, 0 = zero-extend.
- `halted`  out  1  illegal opcode or memory timeout; sticky until reset.

## Operation
- Opcodes: R 0x00, lw 0x23, sw 0x2B, beq 0x04, j 0x02, addi 0x08, andi 0x0C, ori 0x0D; anything else is illegal.
- States and transitions:
  - IDLE -> FETCH on `run`.
  - FETCH holds until `mem_ready` -> DECODE.
  - DECODE branches by opcode: lw/sw -> MEM_ADDR; R -> R_EXEC; beq -> BRANCH; j -> JUMP; addi/andi/ori -> I_EXEC; illegal -> HALT.
  - MEM_ADDR -> MEM_READ (lw) or MEM_WRITE (sw).
  - MEM_READ, on `mem_ready`, -> MEM_WB.
  - MEM_WB, MEM_WRITE (on `mem_ready`), R_WB, I_WB, BRANCH and JUMP -> FETCH.
  - R_EXEC -> R_WB; I_EXEC -> I_WB.
  - HALT is absorbing.
- All outputs default to 0 and are decoded from state; the exceptions qualified by `mem_ready` are listed below.
- FETCH: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00. `ir_write` and `pc_write` equal `mem_ready`.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `ext_sel`=1, `alu_op`=00 (branch target into ALUOut).
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `ext_sel`=1, `alu_op`=00.
- MEM_READ: `mem_read`=1, `iord`=1.
- MEM_WRITE: `mem_write`=1, `iord`=1.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0.
- R_EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10.
- R_WB: `reg_write`=1, `reg_dst`=1.
- I_EXEC: `alu_src_a`=1, `alu_src_b`=10. addi: `ext_sel`=1, `alu_op`=00. andi/ori: `ext_sel`=0, `alu_op`=11.
- I_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01.
- JUMP: `pc_write`=1, `pc_source`=10.
- Memory timeout: a wait counter clears on entry to FETCH, MEM_READ or MEM_WRITE and increments each cycle `mem_ready`=0. Reaching `MEM_TIMEOUT` -> HALT.
- HALT: `halted`=1, all strobes 0.

## Timing
- Reset (asynchronous): state = IDLE, wait counter = 0, all outputs 0.
- Zero-wait-state instruction latencies, FETCH entry to next FETCH entry: R 4, lw 5, sw 4, beq 3, j 3, addi/andi/ori 4. Each memory wait cycle adds 1.
- `run` is sampled only in IDLE; once running, the FSM never returns to IDLE without reset.
- `mem_read`/`mem_write` are held stable for the whole wait and drop the cycle after `mem_ready`.
- Reset asserted mid-instruction: outputs go to 0 immediately (asynchronous). No partial `reg_write` or `mem_write` survives the reset edge.

## Structure
- Package `ctrl_pkg`: state enum, opcode constants, `alu_op`/`alu_src_b`/`pc_source` encodings.
- Sub-module `opcode_class`: combinational opcode -> {R, MEM, BR, J, IMM_S, IMM_Z, ILLEGAL} decoder, reused by the test bench.
- Top level: state register, wait counter, output decode.

## Test plan
- Reset, `run`=1, `mem_ready` tied 1, opcode 0x00 -> FETCH, DECODE, R_EXEC, R_WB; `reg_write`=1 and `reg_dst`=1 in cycle 4 only; FETCH at cycle 5.
- lw (0x23) with `mem_ready` low 2 cycles in MEM_READ -> `mem_read`=1 and `iord`=1 held 3 cycles; `mem_to_reg`=1 in MEM_WB; latency 7.
- beq (0x04) with `zero`=1, then `zero`=0 -> `pc_write_cond`=1, `pc_source`=01, `alu_op`=01 in cycle 3 both times; 3 cycles each.
- andi (0x0C) and addi (0x08) -> `ext_sel`=0 for andi (`alu_op`=11) and `ext_sel`=1 for addi (`alu_op`=00) in I_EXEC.
- opcode 0x3F -> HALT after DECODE, `halted`=1 sticky; `reset_n` pulse -> IDLE with all outputs 0.
- `MEM_TIMEOUT`=4, `mem_ready` held 0 in FETCH -> HALT after 4 wait cycles; `reset_n` low mid-MEM_WRITE -> `mem_write` drops the same cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle datapath controller:
// FSM states, opcode values, opcode classes and datapath mux encodings.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WRITE,
        S_MEM_WB,
        S_R_EXEC,
        S_R_WB,
        S_I_EXEC,
        S_I_WB,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_MEM,
        CLS_BR,
        CLS_J,
        CLS_IMM_S,
        CLS_IMM_Z,
        CLS_ILLEGAL
    } op_class_t;

    localparam logic [5:0] OPC_R    = 6'h00;
    localparam logic [5:0] OPC_LW   = 6'h23;
    localparam logic [5:0] OPC_SW   = 6'h2B;
    localparam logic [5:0] OPC_BEQ  = 6'h04;
    localparam logic [5:0] OPC_J    = 6'h02;
    localparam logic [5:0] OPC_ADDI = 6'h08;
    localparam logic [5:0] OPC_ANDI = 6'h0C;
    localparam logic [5:0] OPC_ORI  = 6'h0D;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_IMM   = 2'b11;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: status inputs to the FSM and every datapath strobe/mux select.
interface multicycle_ctrl_if;
    logic       run;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       ext_sel;
    logic       halted;

    modport master (
        input  run, opcode, zero, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, ext_sel, halted
    );

    modport slave (
        output run, opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, ext_sel, halted
    );
endinterface

// File: rtl/opcode_class.sv
// Combinational opcode decoder: maps IR[31:26] onto the instruction class the FSM branches on.
module opcode_class
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            OPC_R:              op_class = CLS_R;
            OPC_LW, OPC_SW:     op_class = CLS_MEM;
            OPC_BEQ:            op_class = CLS_BR;
            OPC_J:              op_class = CLS_J;
            OPC_ADDI:           op_class = CLS_IMM_S;
            OPC_ANDI, OPC_ORI:  op_class = CLS_IMM_Z;
            default:            op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle datapath control FSM: state register, memory wait/timeout counter
// and state-decoded datapath strobes (FETCH strobes also qualified by mem_ready).
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset_n,
    multicycle_ctrl_if.master  bus
);

    localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            mem_wait;
    op_class_t       op_class;

    opcode_class u_opcode_class (
        .opcode   (bus.opcode),
        .op_class (op_class)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_wait   = 1'b0;
        case (state_q)
            S_IDLE:      if (bus.run) state_d = S_FETCH;
            S_FETCH:     if (bus.mem_ready) state_d = S_DECODE; else mem_wait = 1'b1;
            S_DECODE: begin
                case (op_class)
                    CLS_R:                state_d = S_R_EXEC;
                    CLS_MEM:              state_d = S_MEM_ADDR;
                    CLS_BR:               state_d = S_BRANCH;
                    CLS_J:                state_d = S_JUMP;
                    CLS_IMM_S, CLS_IMM_Z: state_d = S_I_EXEC;
                    default:              state_d = S_HALT;
                endcase
            end
            S_MEM_ADDR:  state_d = (bus.opcode == OPC_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (bus.mem_ready) state_d = S_MEM_WB; else mem_wait = 1'b1;
            S_MEM_WRITE: if (bus.mem_ready) state_d = S_FETCH; else mem_wait = 1'b1;
            S_R_EXEC:    state_d = S_R_WB;
            S_I_EXEC:    state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_HALT;
        endcase

        // Timeout fires on the MEM_TIMEOUT-th consecutive wait cycle.
        if (mem_wait && (MEM_TIMEOUT != 0)) begin
            if (wait_cnt_q == CW'(MEM_TIMEOUT - 1)) state_d = S_HALT;
            else wait_cnt_d = wait_cnt_q + 1'b1;
        end
        // Any state change starts a fresh wait window.
        if (state_d != state_q) wait_cnt_d = '0;
    end

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_B;
        bus.alu_op        = ALU_ADD;
        bus.pc_source     = PCSRC_ALU;
        bus.ext_sel       = 1'b0;
        bus.halted        = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_b = SRCB_IMM_SH;
                bus.ext_sel   = 1'b1;
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.ext_sel   = 1'b1;
            end
            S_MEM_READ: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            S_MEM_WRITE: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_R_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            S_I_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.ext_sel   = (op_class == CLS_IMM_S);
                bus.alu_op    = (op_class == CLS_IMM_S) ? ALU_ADD : ALU_IMM;
            end
            S_I_WB:   bus.reg_write = 1'b1;
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALU_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = PCSRC_JUMP;
            end
            S_HALT:  bus.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: an instruction-level model expands each
// instruction into its per-cycle expected strobes; a negedge monitor compares them.
module tb_multicycle_ctrl;

    localparam logic [5:0] T_R = 6'h00, T_LW = 6'h23, T_SW = 6'h2B, T_BEQ = 6'h04;
    localparam logic [5:0] T_J = 6'h02, T_ADDI = 6'h08, T_ANDI = 6'h0C, T_ORI = 6'h0D;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       ext_sel;
        logic       halted;
    } ctl_t;

    typedef struct {
        ctl_t  exp;
        string lbl;
    } sb_t;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    sb_t         sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    string       cur;
    logic [5:0]  ops   [8] = '{T_R, T_LW, T_SW, T_BEQ, T_J, T_ADDI, T_ANDI, T_ORI};
    string       names [8] = '{"r", "lw", "sw", "beq", "j", "addi", "andi", "ori"};

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected strobes for one cycle of a named instruction phase.
    function automatic ctl_t phase_out(input string ph, input bit rdy, input bit sext);
        ctl_t c = '0;
        if (ph == "FETCH") begin
            c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy;
        end else if (ph == "DECODE") begin
            c.alu_src_b = 2'b11; c.ext_sel = 1'b1;
        end else if (ph == "MEM_ADDR") begin
            c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.ext_sel = 1'b1;
        end else if (ph == "MEM_READ") begin
            c.mem_read = 1'b1; c.iord = 1'b1;
        end else if (ph == "MEM_WRITE") begin
            c.mem_write = 1'b1; c.iord = 1'b1;
        end else if (ph == "MEM_WB") begin
            c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
        end else if (ph == "R_EXEC") begin
            c.alu_src_a = 1'b1; c.alu_op = 2'b10;
        end else if (ph == "R_WB") begin
            c.reg_write = 1'b1; c.reg_dst = 1'b1;
        end else if (ph == "I_EXEC") begin
            c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.ext_sel = sext;
            c.alu_op = sext ? 2'b00 : 2'b11;
        end else if (ph == "I_WB") begin
            c.reg_write = 1'b1;
        end else if (ph == "BRANCH") begin
            c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
        end else if (ph == "JUMP") begin
            c.pc_write = 1'b1; c.pc_source = 2'b10;
        end else if (ph == "HALT") begin
            c.halted = 1'b1;
        end
        return c;
    endfunction

    // One clock of stimulus: drive inputs, queue the expectation, advance to posedge+1.
    task automatic step(input bit rdy, input bit z, input bit rn, input ctl_t e, input string lbl);
        sb_t ent;
        bus.mem_ready = rdy;
        bus.zero      = z;
        bus.run       = rn;
        ent.exp = e;
        ent.lbl = lbl;
        sb_q.push_back(ent);
        @(posedge clock);
        #1;
    endtask

    task automatic ph(input string p, input bit rdy, input bit sext, input bit z);
        step(rdy, z, rb(), phase_out(p, rdy, sext), {cur, ".", p});
    endtask

    task automatic mem_phase(input string p, input int unsigned waits);
        for (int unsigned i = 0; i < waits; i++) ph(p, 1'b0, 1'b0, rb());
        ph(p, 1'b1, 1'b0, rb());
    endtask

    task automatic exec_instr(input logic [5:0] op, input string name,
                              input int unsigned wf, input int unsigned wm, input bit z);
        cur = name;
        for (int unsigned i = 0; i < wf; i++) begin
            bus.opcode = 6'($urandom);
            ph("FETCH", 1'b0, 1'b0, rb());
        end
        bus.opcode = 6'($urandom);
        ph("FETCH", 1'b1, 1'b0, rb());
        bus.opcode = op;
        ph("DECODE", rb(), 1'b0, rb());
        case (op)
            T_R:    begin ph("R_EXEC", rb(), 1'b0, rb()); ph("R_WB", rb(), 1'b0, rb()); end
            T_LW:   begin ph("MEM_ADDR", rb(), 1'b0, rb()); mem_phase("MEM_READ", wm);
                          ph("MEM_WB", rb(), 1'b0, rb()); end
            T_SW:   begin ph("MEM_ADDR", rb(), 1'b0, rb()); mem_phase("MEM_WRITE", wm); end
            T_BEQ:  ph("BRANCH", rb(), 1'b0, z);
            T_J:    ph("JUMP", rb(), 1'b0, rb());
            T_ADDI: begin ph("I_EXEC", rb(), 1'b1, rb()); ph("I_WB", rb(), 1'b0, rb()); end
            T_ANDI, T_ORI: begin ph("I_EXEC", rb(), 1'b0, rb()); ph("I_WB", rb(), 1'b0, rb()); end
            default: for (int unsigned i = 0; i < 3; i++) ph("HALT", rb(), 1'b0, rb());
        endcase
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(rb(), rb(), rb(), '0, "reset");
        step(rb(), rb(), rb(), '0, "reset");
        reset_n = 1'b1;
        step(rb(), rb(), 1'b0, '0, "idle");
    endtask

    task automatic start_run();
        step(rb(), rb(), 1'b1, '0, "idle_run");
    endtask

    // Monitor: one comparison per cycle while expectations are pending.
    ctl_t act;
    sb_t  mon;
    initial begin
        forever begin
            @(negedge clock);
            if (sb_q.size() > 0) begin
                mon = sb_q.pop_front();
                act = '{bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
                        bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                        bus.alu_src_b, bus.alu_op, bus.pc_source, bus.ext_sel, bus.halted};
                n_checks++;
                if (act === mon.exp) n_pass++;
                else $display("FAIL %s: got %05h expected %05h (t=%0t)", mon.lbl, act, mon.exp, $time);
            end
        end
    end

    initial begin
        int unsigned k;
        reset_n       = 1'b0;
        bus.run       = 1'b0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        bus.opcode    = '0;
        @(posedge clock);
        #1;

        do_reset();
        start_run();
        exec_instr(T_R,    "r_first",  0, 0, 1'b0);
        exec_instr(T_LW,   "lw_wait2", 0, 2, 1'b0);
        exec_instr(T_BEQ,  "beq_z1",   0, 0, 1'b1);
        exec_instr(T_BEQ,  "beq_z0",   0, 0, 1'b0);
        exec_instr(T_ANDI, "andi",     0, 0, 1'b0);
        exec_instr(T_ADDI, "addi",     0, 0, 1'b0);
        exec_instr(T_SW,   "sw_wait1", 1, 1, 1'b0);

        for (int unsigned i = 0; i < 60; i++) begin
            k = $urandom_range(0, 7);
            exec_instr(ops[k], names[k], $urandom_range(0, 3), $urandom_range(0, 3), rb());
        end

        exec_instr(6'h3F, "illegal", 0, 0, 1'b0);
        do_reset();
        start_run();

        cur = "timeout";
        for (int unsigned i = 0; i < 4; i++) ph("FETCH", 1'b0, 1'b0, rb());
        for (int unsigned i = 0; i < 3; i++) ph("HALT", rb(), 1'b0, rb());

        do_reset();
        start_run();
        cur = "sw_rst";
        ph("FETCH", 1'b1, 1'b0, rb());
        bus.opcode = T_SW;
        ph("DECODE", rb(), 1'b0, rb());
        ph("MEM_ADDR", rb(), 1'b0, rb());
        ph("MEM_WRITE", 1'b0, 1'b0, rb());
        reset_n = 1'b0;
        step(1'b0, rb(), rb(), '0, "sw_rst.async_reset");
        reset_n = 1'b1;
        step(rb(), rb(), 1'b0, '0, "sw_rst.idle");

        for (int unsigned i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clock);
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
